// File: rtl/tlbfill_ctl_if.sv
// Write-port bundle between the TLB fill sequencer (slave) and the
// requester / TLB group side (master).
interface tlbfill_ctl_if #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 15
);
  logic             fill_req_h;
  logic             tbis_req_h;
  logic             tbia_req_h;
  logic [IDX_W-1:0] req_idx_h;
  logic [TAG_W-1:0] req_tag_h;
  logic [19:0]      req_data_h;
  logic             hit_h;
  logic             tag_perr_h;
  logic             err_clr_h;
  logic             busy_h;
  logic             done_h;
  logic             fill_err_h;
  logic [IDX_W-1:0] index_h;
  logic             in_valid_h;
  logic [TAG_W-1:0] in_tag_h;
  logic             tag_par_in_h;
  logic [19:0]      data_h;
  logic [2:0]       data_par_in_h;
  logic             write_h;

  modport master (
    output fill_req_h, tbis_req_h, tbia_req_h, req_idx_h, req_tag_h, req_data_h,
           hit_h, tag_perr_h, err_clr_h,
    input  busy_h, done_h, fill_err_h, index_h, in_valid_h, in_tag_h,
           tag_par_in_h, data_h, data_par_in_h, write_h
  );

  modport slave (
    input  fill_req_h, tbis_req_h, tbia_req_h, req_idx_h, req_tag_h, req_data_h,
           hit_h, tag_perr_h, err_clr_h,
    output busy_h, done_h, fill_err_h, index_h, in_valid_h, in_tag_h,
           tag_par_in_h, data_h, data_par_in_h, write_h
  );
endinterface

// File: rtl/tlbfill_ctl.sv
// Write-side sequencer for one TLB group: fill with readback check,
// single-entry invalidate and invalidate-all sweep.
module tlbfill_ctl #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 15
) (
  input logic          b_clk_l,
  input logic          reset_l,
  tlbfill_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FWR,
    FCHK,
    IWR,
    SWEEP
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX    = '1;
  localparam logic [IDX_W-1:0] LAST_IDX_M1 = LAST_IDX - 1'b1;

  state_t state;

  // Parity follows the registered write values, so readback never reports a tag parity error.
  assign bus.tag_par_in_h     = ~^{bus.in_valid_h, bus.in_tag_h};
  assign bus.data_par_in_h[0] = ~^bus.data_h[7:0];
  assign bus.data_par_in_h[1] = ~^bus.data_h[15:8];
  assign bus.data_par_in_h[2] = ~^bus.data_h[19:16];

  always_ff @(posedge b_clk_l) begin
    if (!reset_l) begin
      state          <= IDLE;
      bus.busy_h     <= 1'b0;
      bus.done_h     <= 1'b0;
      bus.fill_err_h <= 1'b0;
      bus.index_h    <= '0;
      bus.in_valid_h <= 1'b0;
      bus.in_tag_h   <= '0;
      bus.data_h     <= '0;
      bus.write_h    <= 1'b0;
    end else begin
      bus.write_h <= 1'b0;
      bus.done_h  <= 1'b0;
      // A readback failure in FCHK is assigned later and overrides a clear.
      if (bus.err_clr_h) begin
        bus.fill_err_h <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.tbia_req_h) begin
            state          <= SWEEP;
            bus.busy_h     <= 1'b1;
            bus.write_h    <= 1'b1;
            bus.index_h    <= '0;
            bus.in_valid_h <= 1'b0;
            bus.in_tag_h   <= '0;
            bus.data_h     <= '0;
          end else if (bus.tbis_req_h) begin
            state          <= IWR;
            bus.busy_h     <= 1'b1;
            bus.write_h    <= 1'b1;
            bus.done_h     <= 1'b1;
            bus.index_h    <= bus.req_idx_h;
            bus.in_valid_h <= 1'b0;
            bus.in_tag_h   <= '0;
            bus.data_h     <= '0;
          end else if (bus.fill_req_h) begin
            state          <= FWR;
            bus.busy_h     <= 1'b1;
            bus.write_h    <= 1'b1;
            bus.index_h    <= bus.req_idx_h;
            bus.in_valid_h <= 1'b1;
            bus.in_tag_h   <= bus.req_tag_h;
            bus.data_h     <= bus.req_data_h;
          end
        end

        FWR: begin
          state <= FCHK;
        end

        // Index and tag stay on the bus so the group compares against the entry just written.
        FCHK: begin
          if (!bus.hit_h || bus.tag_perr_h) begin
            bus.fill_err_h <= 1'b1;
          end
          bus.done_h <= 1'b1;
          bus.busy_h <= 1'b0;
          state      <= IDLE;
        end

        IWR: begin
          bus.busy_h <= 1'b0;
          state      <= IDLE;
        end

        SWEEP: begin
          if (bus.index_h == LAST_IDX) begin
            bus.index_h <= '0;
            bus.busy_h  <= 1'b0;
            state       <= IDLE;
          end else begin
            bus.index_h <= bus.index_h + 1'b1;
            bus.write_h <= 1'b1;
            if (bus.index_h == LAST_IDX_M1) begin
              bus.done_h <= 1'b1;
            end
          end
        end

        default: begin
          bus.busy_h <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlbfill_ctl.sv
// Randomized scoreboard bench for tlbfill_ctl: every write/done event the
// DUT shows is matched against a queue of events predicted from the op list.
module tb_tlbfill_ctl;
  localparam int IDX_W = 8;
  localparam int TAG_W = 15;

  logic b_clk_l = 1'b0;
  logic reset_l;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic err_m;

  typedef struct {
    int          cyc;
    logic        wr;
    logic        dn;
    logic [7:0]  idx;
    logic        vld;
    logic [14:0] tag;
    logic [19:0] data;
    logic        err;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic       exp_tpar;
  logic [2:0] exp_dpar;

  tlbfill_ctl_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  tlbfill_ctl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .b_clk_l (b_clk_l),
    .reset_l (reset_l),
    .bus     (bus.slave)
  );

  always #5 b_clk_l = ~b_clk_l;

  always @(posedge b_clk_l) cyc <= cyc + 1;

  // Reference parity: 1 when the field holds an even number of ones
  function automatic logic even_par(input logic [31:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  function automatic ev_t mk_ev(input int c, input logic wr, input logic dn,
                                input logic [7:0] idx, input logic vld,
                                input logic [14:0] tag, input logic [19:0] data,
                                input logic err);
    ev_t e;
    e.cyc = c; e.wr = wr; e.dn = dn; e.idx = idx;
    e.vld = vld; e.tag = tag; e.data = data; e.err = err;
    return e;
  endfunction

  // Monitor: every cycle with write_h or done_h consumes one predicted event
  always @(negedge b_clk_l) begin
    if (bus.write_h === 1'b1 || bus.done_h === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event cyc=%0d actual write=%0b done=%0b index=%0h required no event",
                 cyc, bus.write_h, bus.done_h, bus.index_h);
      end else begin
        mon_e    = exp_q.pop_front();
        exp_tpar = even_par({16'b0, mon_e.vld, mon_e.tag});
        exp_dpar = {even_par({28'b0, mon_e.data[19:16]}),
                    even_par({24'b0, mon_e.data[15:8]}),
                    even_par({24'b0, mon_e.data[7:0]})};
        if (cyc != mon_e.cyc || bus.write_h !== mon_e.wr || bus.done_h !== mon_e.dn ||
            bus.index_h !== mon_e.idx || bus.in_valid_h !== mon_e.vld ||
            bus.in_tag_h !== mon_e.tag || bus.data_h !== mon_e.data ||
            bus.tag_par_in_h !== exp_tpar || bus.data_par_in_h !== exp_dpar ||
            bus.fill_err_h !== mon_e.err) begin
          errors++;
          $display("[TB] FAIL event actual cyc=%0d wr=%0b dn=%0b idx=%h v=%0b tag=%h data=%h tp=%0b dp=%b err=%0b required cyc=%0d wr=%0b dn=%0b idx=%h v=%0b tag=%h data=%h tp=%0b dp=%b err=%0b",
                   cyc, bus.write_h, bus.done_h, bus.index_h, bus.in_valid_h, bus.in_tag_h,
                   bus.data_h, bus.tag_par_in_h, bus.data_par_in_h, bus.fill_err_h,
                   mon_e.cyc, mon_e.wr, mon_e.dn, mon_e.idx, mon_e.vld, mon_e.tag,
                   mon_e.data, exp_tpar, exp_dpar, mon_e.err);
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge b_clk_l);
    #1;
  endtask

  // Fill: write at +1, check cycle at +2, done at +3 counted from the request cycle
  task automatic do_fill(input logic [7:0] idx, input logic [14:0] tag, input logic [19:0] data,
                         input logic hit, input logic perr, input logic clr);
    int   d;
    logic new_err;
    d       = cyc;
    new_err = (!hit || perr) ? 1'b1 : (clr ? 1'b0 : err_m);
    bus.fill_req_h = 1'b1;
    bus.req_idx_h  = idx;
    bus.req_tag_h  = tag;
    bus.req_data_h = data;
    exp_q.push_back(mk_ev(d + 1, 1'b1, 1'b0, idx, 1'b1, tag, data, err_m));
    exp_q.push_back(mk_ev(d + 3, 1'b0, 1'b1, idx, 1'b1, tag, data, new_err));
    step();
    bus.fill_req_h = 1'b0;
    bus.req_idx_h  = 8'($urandom);
    bus.req_tag_h  = 15'($urandom);
    bus.req_data_h = 20'($urandom);
    check_val("fill_busy_wr", {31'b0, bus.busy_h}, 32'd1);
    step();
    check_val("fill_busy_chk", {31'b0, bus.busy_h}, 32'd1);
    bus.hit_h      = hit;
    bus.tag_perr_h = perr;
    bus.err_clr_h  = clr;
    step();
    bus.hit_h      = 1'b0;
    bus.tag_perr_h = 1'b1;
    bus.err_clr_h  = 1'b0;
    err_m = new_err;
    check_val("fill_busy_done", {31'b0, bus.busy_h}, 32'd0);
    check_val("fill_err_after", {31'b0, bus.fill_err_h}, {31'b0, err_m});
  endtask

  task automatic do_tbis(input logic [7:0] idx);
    int d;
    d = cyc;
    bus.tbis_req_h = 1'b1;
    bus.req_idx_h  = idx;
    exp_q.push_back(mk_ev(d + 1, 1'b1, 1'b1, idx, 1'b0, 15'h0, 20'h0, err_m));
    step();
    bus.tbis_req_h = 1'b0;
    check_val("tbis_busy", {31'b0, bus.busy_h}, 32'd1);
    step();
  endtask

  task automatic do_idle_clr();
    bus.err_clr_h = 1'b1;
    step();
    bus.err_clr_h = 1'b0;
    err_m = 1'b0;
    check_val("idle_clr", {31'b0, bus.fill_err_h}, 32'd0);
  endtask

  // Sweep of all 256 entries; optional request noise, combined request, or reset abort
  task automatic do_tbia(input int abort_at, input bit noise, input bit combo);
    int d;
    int n;
    d = cyc;
    n = (abort_at < 0) ? 256 : abort_at + 1;
    bus.tbia_req_h = 1'b1;
    if (combo) begin
      bus.tbis_req_h = 1'b1;
      bus.fill_req_h = 1'b1;
      bus.req_idx_h  = 8'($urandom);
    end
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk_ev(d + 1 + i, 1'b1, (i == 255), 8'(i), 1'b0, 15'h0, 20'h0, err_m));
    step();
    bus.tbia_req_h = 1'b0;
    bus.tbis_req_h = 1'b0;
    bus.fill_req_h = 1'b0;
    check_val("tbia_busy", {31'b0, bus.busy_h}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      if (i == abort_at) begin
        reset_l = 1'b0;
        step();
        check_val("abort_busy",  {31'b0, bus.busy_h},  32'd0);
        check_val("abort_write", {31'b0, bus.write_h}, 32'd0);
        check_val("abort_index", {24'b0, bus.index_h}, 32'd0);
        check_val("abort_done",  {31'b0, bus.done_h},  32'd0);
        reset_l = 1'b1;
        err_m   = 1'b0;
        return;
      end
      if (i == 128) check_val("sweep_busy_mid", {31'b0, bus.busy_h}, 32'd1);
      if (noise) begin
        bus.fill_req_h = 1'($urandom_range(0, 1));
        bus.tbis_req_h = 1'($urandom_range(0, 1));
        bus.req_idx_h  = 8'($urandom);
      end
      step();
    end
    bus.fill_req_h = 1'b0;
    bus.tbis_req_h = 1'b0;
    check_val("tbia_idle_after", {31'b0, bus.busy_h}, 32'd0);
  endtask

  initial begin
    int op;
    reset_l        = 1'b0;
    err_m          = 1'b0;
    bus.fill_req_h = 1'b0;
    bus.tbis_req_h = 1'b0;
    bus.tbia_req_h = 1'b0;
    bus.req_idx_h  = '0;
    bus.req_tag_h  = '0;
    bus.req_data_h = '0;
    bus.hit_h      = 1'b0;
    bus.tag_perr_h = 1'b1;
    bus.err_clr_h  = 1'b0;
    repeat (3) step();
    check_val("rst_busy",   {31'b0, bus.busy_h},     32'd0);
    check_val("rst_done",   {31'b0, bus.done_h},     32'd0);
    check_val("rst_err",    {31'b0, bus.fill_err_h}, 32'd0);
    check_val("rst_index",  {24'b0, bus.index_h},    32'd0);
    check_val("rst_valid",  {31'b0, bus.in_valid_h}, 32'd0);
    check_val("rst_tag",    {17'b0, bus.in_tag_h},   32'd0);
    check_val("rst_data",   {12'b0, bus.data_h},     32'd0);
    check_val("rst_write",  {31'b0, bus.write_h},    32'd0);
    check_val("rst_dpar",   {29'b0, bus.data_par_in_h}, 32'd7);
    reset_l = 1'b1;
    step();

    $display("[TB] directed fill");
    do_fill(8'h3C, 15'h1234, 20'hABCDE, 1'b1, 1'b0, 1'b0);
    check_val("fill_tag_par", {31'b0, bus.tag_par_in_h}, 32'd1);

    $display("[TB] fill error sticky / clear");
    do_fill(8'h11, 15'h0ABC, 20'h12345, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check_val("err_sticky", {31'b0, bus.fill_err_h}, 32'd1);
    do_idle_clr();
    do_fill(8'h22, 15'h7FFF, 20'h0F0F0, 1'b0, 1'b0, 1'b1);
    check_val("err_set_wins", {31'b0, bus.fill_err_h}, 32'd1);
    do_fill(8'h23, 15'h0001, 20'h00100, 1'b1, 1'b1, 1'b0);
    do_idle_clr();

    $display("[TB] data parity");
    do_fill(8'h01, 15'h0002, 20'h00001, 1'b1, 1'b0, 1'b0);
    check_val("dpar_01", {29'b0, bus.data_par_in_h}, 32'd6);
    do_fill(8'h02, 15'h0003, 20'h00000, 1'b1, 1'b0, 1'b0);
    check_val("dpar_00", {29'b0, bus.data_par_in_h}, 32'd7);

    $display("[TB] tbia with ignored requests");
    do_tbia(-1, 1'b1, 1'b0);

    $display("[TB] combined requests then tbis");
    do_tbia(-1, 1'b0, 1'b1);
    do_tbis(8'h7F);

    $display("[TB] random ops");
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 5)
        do_fill(8'($urandom), 15'($urandom), 20'($urandom),
                1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 4) == 0));
      else if (op <= 8)
        do_tbis(8'($urandom));
      else
        do_idle_clr();
    end

    $display("[TB] reset during sweep");
    do_tbia(100, 1'b0, 1'b0);
    step();
    do_fill(8'h55, 15'h2AAA, 20'h55555, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check_val("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
